tec8_datapath: RTL
==================

// Module: tec8_datapath
// PURPOSE
//   Execution datapath driven by the hardwired controller's control word. Holds the
//   4x8 register file, an ALU in 74181 style, PC, AR, IR and the C/Z flags.
//   All state updates on the t3 rising edge. Returns ir/c/z to the controller,
//   closing the controller <-> datapath loop. Drives the external memory port.
// PARAMETERS
//   W      8  data/address width; all arithmetic wraps mod 2^W
//   NREG   4  register-file depth, indexed by 2-bit fields
// PORTS
//   t3         in   1  clock; all state changes on rising edge
//   clr        in   1  asynchronous active-low reset
//   drw,lpc,lar,pcinc,pcadd,arinc,lir,ldc,ldz,memw,selctl
//              in   1  each  controller load/enable strobes
//   s          in   4  ALU function select
//   m          in   1  ALU mode: 1 = logic, 0 = arithmetic
//   cin        in   1  ALU carry-in, active-low (74181 convention)
//   abus,sbus,mbus in 1  dbus source enables: ALU / switches / memory
//   sel3..sel0 in   1  each  panel register selects, used when selctl=1
//   sw_data    in   W  front-panel data switches
//   mem_rdata  in   W  memory read data
//   ir         out  W  instruction register; controller consumes ir[7:4]
//   c, z       out  1  carry and zero flags
//   pc, ar     out  W  program counter, address register
//   mem_addr   out  W  lir ? pc : ar (combinational)
//   mem_wdata  out  W  = dbus;  mem_we  out 1  = memw (combinational)
//   dbus       out  W  internal data bus
//   reg_a, reg_b out W  ALU A/B operands, for panel display
//   bus_err    out  1  sticky flag: more than one dbus source enabled
// BEHAVIOUR
// - Reset (clr=0, async): R0-R3, pc, ar, ir, c, z and bus_err all 0.
//   Combinational outputs follow from these cleared values.
// - Register selection
//   - selctl=1: dest = A = {sel3,sel2}; B = {sel1,sel0}.
//   - selctl=0: dest = A = ir[3:2]; B = ir[1:0].
// - Reads are combinational. A write takes effect at the edge, so a read of the
//   register being written returns the old value during that cycle.
// - ALU, M=1: s=1111 -> A; 1010 -> B; 1011 -> A&B; 0110 -> A^B; 1110 -> A|B;
//   0000 -> ~A. Any other code -> A. Logic ops produce carry 0.
// - ALU, M=0: 9-bit sums; carry = bit W of the sum.
//   - s=1001,cin=1: A+B
//   - s=0110,cin=0: A+~B+1
//   - s=0000,cin=0: A+1
//   - s=1111,cin=1: A+{W{1}}
//   - any other s/cin combination: A, carry 0.
// - dbus source: abus -> ALU, else mbus -> mem_rdata, else sbus -> sw_data,
//   else 0. bus_err sets at the edge whenever >=2 of abus/mbus/sbus are high.
//   Only reset clears it.
// - Edge updates (all sampled at the t3 rising edge):
//   - drw: R[dest] <= dbus.
//   - lir: ir <= mem_rdata.
//   - PC, priority lpc > pcadd > pcinc:
//     - lpc: pc <= dbus
//     - pcadd: pc <= pc + sext(ir[3:0])
//     - pcinc: pc <= pc+1
//   - AR, priority lar > arinc: lar -> ar <= dbus; arinc -> ar <= ar+1.
//   - ldc: c <= ALU carry.  ldz: z <= (ALU result == 0). Independent of each other.
// - lir, pcinc and pcadd together in one cycle: ir loads, pcadd wins over pcinc.
// - Wrap: pc and ar go FF -> 00 with no flag.
//   pcadd with ir[3:0]=1000 subtracts 8 (mod 256).
// - Reset mid-cycle: asserting clr between edges clears state immediately.
//   An edge while clr=0 updates nothing.
// - No handshake: each strobe acts at exactly one edge. Latency: 1 edge from
//   control word to state; combinational outputs settle in the same cycle.
// TESTING
// - Reset: clr=0 with all strobes active -> all state 0, bus_err=0.
//   After clr=1 and one idle edge, still 0.
// - Panel write/read: selctl=1, {sel3,sel2}=10, sbus=1, sw_data=5A, drw=1,
//   one edge -> R2=5A. Then sel1,sel0=10 -> reg_b=5A.
// - ADD flags: R0=F0, R1=20, ir=0001_0001, s=1001, m=0, cin=1, abus, drw, ldc, ldz
//   -> R0=10, c=1, z=0.
//   SUB with R0=R1=33 (s=0110, cin=0) -> R0=00, c=1, z=1.
// - Fetch/jump: pc=FF, lir=1, pcinc=1, mem_rdata=72 -> ir=72, pc=00.
//   Then pcadd with ir[3:0]=E -> pc=FE.
//   lpc together with pcadd, dbus=40 -> pc=40.
// - AR/memory: lar with sw_data=80, then arinc x2 -> ar=82, mem_addr=82.
//   memw=1, abus, s=1111, m=1, A=3C -> mem_we=1, mem_wdata=3C.
// - Bus conflict: abus=1 and sbus=1 -> dbus = ALU result, bus_err=1 after the edge,
//   stays 1 after both drop. Async clr pulse mid-cycle -> 0 immediately.

Source files
------------

// File: rtl/tec8_datapath_if.sv
// External memory port of the TEC-8 datapath: address/write data/write enable out, read data in.
// The datapath is the master; the memory model or controller-side glue is the slave.
interface tec8_datapath_if #(parameter int W = 8);
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_we;
  logic [W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/tec8_datapath.sv
// TEC-8 execution datapath: 4x8 register file, 74181-style ALU, PC/AR/IR and C/Z flags.
// All state loads at the t3 rising edge; reads, ALU, dbus and memory port are combinational.
module tec8_datapath #(
  parameter int W    = 8,
  parameter int NREG = 4
) (
  input  logic          t3,
  input  logic          clr,
  input  logic          drw,
  input  logic          lpc,
  input  logic          lar,
  input  logic          pcinc,
  input  logic          pcadd,
  input  logic          arinc,
  input  logic          lir,
  input  logic          ldc,
  input  logic          ldz,
  input  logic          memw,
  input  logic          selctl,
  input  logic [3:0]    s,
  input  logic          m,
  input  logic          cin,
  input  logic          abus,
  input  logic          sbus,
  input  logic          mbus,
  input  logic          sel3,
  input  logic          sel2,
  input  logic          sel1,
  input  logic          sel0,
  input  logic [W-1:0]  sw_data,
  output logic [W-1:0]  ir,
  output logic          c,
  output logic          z,
  output logic [W-1:0]  pc,
  output logic [W-1:0]  ar,
  output logic [W-1:0]  dbus,
  output logic [W-1:0]  reg_a,
  output logic [W-1:0]  reg_b,
  output logic          bus_err,
  tec8_datapath_if.master mem
);

  logic [W-1:0] rf [NREG];
  logic [1:0]   sel_a;
  logic [1:0]   sel_b;
  logic [W-1:0] alu_res;
  logic         alu_cy;
  logic [W:0]   sum;
  logic         bus_conflict;

  assign sel_a = selctl ? {sel3, sel2} : ir[3:2];
  assign sel_b = selctl ? {sel1, sel0} : ir[1:0];
  assign reg_a = rf[sel_a];
  assign reg_b = rf[sel_b];

  // Only the four listed arithmetic encodings are decoded; everything else passes A through.
  always_comb begin
    alu_res = reg_a;
    alu_cy  = 1'b0;
    sum     = '0;
    if (m) begin
      case (s)
        4'b1111: alu_res = reg_a;
        4'b1010: alu_res = reg_b;
        4'b1011: alu_res = reg_a & reg_b;
        4'b0110: alu_res = reg_a ^ reg_b;
        4'b1110: alu_res = reg_a | reg_b;
        4'b0000: alu_res = ~reg_a;
        default: alu_res = reg_a;
      endcase
    end else begin
      case ({s, cin})
        5'b1001_1: sum = {1'b0, reg_a} + {1'b0, reg_b};
        5'b0110_0: sum = {1'b0, reg_a} + {1'b0, ~reg_b} + {{W{1'b0}}, 1'b1};
        5'b0000_0: sum = {1'b0, reg_a} + {{W{1'b0}}, 1'b1};
        5'b1111_1: sum = {1'b0, reg_a} + {1'b0, {W{1'b1}}};
        default:   sum = {1'b0, reg_a};
      endcase
      alu_res = sum[W-1:0];
      alu_cy  = sum[W];
    end
  end

  always_comb begin
    dbus = '0;
    if (abus)      dbus = alu_res;
    else if (mbus) dbus = mem.mem_rdata;
    else if (sbus) dbus = sw_data;
  end

  assign bus_conflict  = (abus & mbus) | (abus & sbus) | (mbus & sbus);
  assign mem.mem_addr  = lir ? pc : ar;
  assign mem.mem_wdata = dbus;
  assign mem.mem_we    = memw;

  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      pc      <= '0;
      ar      <= '0;
      ir      <= '0;
      c       <= 1'b0;
      z       <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (drw) rf[sel_a] <= dbus;
      if (lir) ir <= mem.mem_rdata;
      // pcadd uses the pre-edge ir even when lir loads a new one at the same edge.
      if (lpc)        pc <= dbus;
      else if (pcadd) pc <= pc + {{(W-4){ir[3]}}, ir[3:0]};
      else if (pcinc) pc <= pc + {{(W-1){1'b0}}, 1'b1};
      if (lar)        ar <= dbus;
      else if (arinc) ar <= ar + {{(W-1){1'b0}}, 1'b1};
      if (ldc) c <= alu_cy;
      if (ldz) z <= (alu_res == '0);
      if (bus_conflict) bus_err <= 1'b1;
    end
  end

endmodule
